// File: rtl/vend_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_pkg : shared widths, state encoding and helpers for the     |
// |            vending item store responder.                         |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
package vend_pkg;

    localparam int COST_W  = 16;
    localparam int AVAIL_W = 8;

    localparam logic [COST_W-1:0] OOR_COST = 16'hFFFF;

    typedef enum logic [1:0] {
        ST_INIT  = 2'd0,
        ST_READY = 2'd1,
        ST_CFG   = 2'd2
    } state_t;

    // Address width for a given slot count; never below one bit.
    function automatic int calc_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [AVAIL_W-1:0] sat_dec(input logic [AVAIL_W-1:0] v);
        return (v == '0) ? v : v - AVAIL_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vend_read_pipe.sv
`default_nettype none
// +------------------------------------------------------------------+
// | vend_read_pipe : fixed-latency read response shift register that |
// |                  snoops dispense updates to keep stock current.  |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module vend_read_pipe
    import vend_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ADDR_W  = 10
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               in_valid,
    input  logic [ADDR_W-1:0]  in_addr,
    input  logic [COST_W-1:0]  in_cost,
    input  logic [AVAIL_W-1:0] in_avail,
    input  logic               snoop_en,
    input  logic [ADDR_W-1:0]  snoop_addr,
    output logic               out_valid,
    output logic [COST_W-1:0]  out_cost,
    output logic [AVAIL_W-1:0] out_avail
);

    logic [LATENCY-1:0] valid_q, valid_d;
    logic [ADDR_W-1:0]  addr_q  [LATENCY];
    logic [ADDR_W-1:0]  addr_d  [LATENCY];
    logic [COST_W-1:0]  cost_q  [LATENCY];
    logic [COST_W-1:0]  cost_d  [LATENCY];
    logic [AVAIL_W-1:0] avail_q [LATENCY];
    logic [AVAIL_W-1:0] avail_d [LATENCY];

    // Empty slots carry zeros so the last stage can drive outputs directly.
    always_comb begin
        valid_d[0] = in_valid;
        addr_d[0]  = in_valid ? in_addr  : '0;
        cost_d[0]  = in_valid ? in_cost  : '0;
        avail_d[0] = in_valid ? in_avail : '0;
        for (int i = 1; i < LATENCY; i++) begin
            valid_d[i] = valid_q[i-1];
            addr_d[i]  = addr_q[i-1];
            cost_d[i]  = cost_q[i-1];
            if (snoop_en && valid_q[i-1] && (addr_q[i-1] == snoop_addr)) begin
                avail_d[i] = sat_dec(avail_q[i-1]);
            end else begin
                avail_d[i] = avail_q[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i]  <= '0;
                cost_q[i]  <= '0;
                avail_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            for (int i = 0; i < LATENCY; i++) begin
                addr_q[i]  <= addr_d[i];
                cost_q[i]  <= cost_d[i];
                avail_q[i] <= avail_d[i];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_cost  = cost_q[LATENCY-1];
    assign out_avail = avail_q[LATENCY-1];

endmodule
`default_nettype wire

// File: rtl/item_store_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | item_store_responder : per-item cost/stock store answering FSM   |
// |   reads, dispense updates and operator config writes.            |
// | Optional: VEND_SALES_COUNT_EN adds the total_sold counter.       |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module item_store_responder
    import vend_pkg::*;
#(
    parameter  int MAX_ITEMS    = 1024,
    parameter  int READ_LATENCY = 2,
    localparam int ADDR_W       = calc_addr_w(MAX_ITEMS)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               cfg_mode,
    input  logic               cfg_write_en,
    input  logic [ADDR_W-1:0]  cfg_addr,
    input  logic [COST_W-1:0]  cfg_cost,
    input  logic [AVAIL_W-1:0] cfg_avail,
    input  logic               mem_read_en,
    input  logic [ADDR_W-1:0]  mem_read_addr,
    input  logic               mem_update_en,
    input  logic [ADDR_W-1:0]  mem_update_addr,
    output logic [COST_W-1:0]  mem_item_cost,
    output logic [AVAIL_W-1:0] mem_item_available,
    output logic               mem_data_valid,
    output logic               busy,
`ifdef VEND_SALES_COUNT_EN
    output logic [31:0]        total_sold,
`endif
    output logic               upd_underflow
);

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  init_cnt_q, init_cnt_d;
    logic               busy_q, busy_d;
    logic               upd_underflow_q, upd_underflow_d;

    logic [COST_W-1:0]  mem_cost_q  [MAX_ITEMS];
    logic [AVAIL_W-1:0] mem_avail_q [MAX_ITEMS];

    logic               wr_en, wr_cost_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [COST_W-1:0]  wr_cost;
    logic [AVAIL_W-1:0] wr_avail;

    logic               rd_in_range, upd_in_range, cfg_in_range;
    logic               active, rd_acc, upd_acc, cfg_acc;
    logic [AVAIL_W-1:0] upd_avail_pre;
    logic [COST_W-1:0]  rd_cost;
    logic [AVAIL_W-1:0] rd_avail;

    generate
        if (MAX_ITEMS == (1 << ADDR_W)) begin : g_full_range
            assign rd_in_range  = 1'b1;
            assign upd_in_range = 1'b1;
            assign cfg_in_range = 1'b1;
        end else begin : g_partial_range
            assign rd_in_range  = (mem_read_addr   < ADDR_W'(MAX_ITEMS));
            assign upd_in_range = (mem_update_addr < ADDR_W'(MAX_ITEMS));
            assign cfg_in_range = (cfg_addr        < ADDR_W'(MAX_ITEMS));
        end
    endgenerate

    // Operator mode blocks FSM traffic as soon as cfg_mode rises, not a cycle later.
    assign active  = (state_q != ST_INIT);
    assign rd_acc  = active && !cfg_mode && mem_read_en;
    assign upd_acc = active && !cfg_mode && mem_update_en && upd_in_range;
    assign cfg_acc = active &&  cfg_mode && cfg_write_en  && cfg_in_range;

    assign upd_avail_pre = upd_in_range ? mem_avail_q[mem_update_addr] : '0;

    always_comb begin
        rd_cost  = OOR_COST;
        rd_avail = '0;
        if (rd_in_range) begin
            rd_cost  = mem_cost_q[mem_read_addr];
            rd_avail = mem_avail_q[mem_read_addr];
            if (upd_acc && (mem_update_addr == mem_read_addr)) begin
                rd_avail = sat_dec(rd_avail);
            end
        end
    end

    always_comb begin
        state_d         = state_q;
        init_cnt_d      = init_cnt_q;
        busy_d          = 1'b0;
        upd_underflow_d = upd_acc && (upd_avail_pre == '0);
        wr_en           = 1'b0;
        wr_cost_en      = 1'b0;
        wr_addr         = '0;
        wr_cost         = '0;
        wr_avail        = '0;

        unique case (state_q)
            ST_INIT: begin
                busy_d = 1'b1;
                // First cycle out of reset only raises busy; the sweep follows.
                if (busy_q) begin
                    wr_en      = 1'b1;
                    wr_cost_en = 1'b1;
                    wr_addr    = init_cnt_q;
                    init_cnt_d = init_cnt_q + ADDR_W'(1);
                    if (init_cnt_q == ADDR_W'(MAX_ITEMS - 1)) begin
                        state_d    = ST_READY;
                        busy_d     = 1'b0;
                        init_cnt_d = '0;
                    end
                end
            end
            ST_READY: begin
                if (cfg_mode) begin
                    state_d = ST_CFG;
                end
            end
            ST_CFG: begin
                if (!cfg_mode) begin
                    state_d = ST_READY;
                end
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase

        if (cfg_acc) begin
            wr_en      = 1'b1;
            wr_cost_en = 1'b1;
            wr_addr    = cfg_addr;
            wr_cost    = cfg_cost;
            wr_avail   = cfg_avail;
        end else if (upd_acc) begin
            wr_en    = 1'b1;
            wr_addr  = mem_update_addr;
            wr_avail = sat_dec(upd_avail_pre);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= ST_INIT;
            init_cnt_q      <= '0;
            busy_q          <= 1'b0;
            upd_underflow_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            init_cnt_q      <= init_cnt_d;
            busy_q          <= busy_d;
            upd_underflow_q <= upd_underflow_d;
        end
    end

    // Storage is cleared by the INIT sweep, so it needs no reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_avail_q[wr_addr] <= wr_avail;
            if (wr_cost_en) begin
                mem_cost_q[wr_addr] <= wr_cost;
            end
        end
    end

    vend_read_pipe #(
        .LATENCY (READ_LATENCY),
        .ADDR_W  (ADDR_W)
    ) u_read_pipe (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (rd_acc),
        .in_addr    (mem_read_addr),
        .in_cost    (rd_cost),
        .in_avail   (rd_avail),
        .snoop_en   (upd_acc),
        .snoop_addr (mem_update_addr),
        .out_valid  (mem_data_valid),
        .out_cost   (mem_item_cost),
        .out_avail  (mem_item_available)
    );

`ifdef VEND_SALES_COUNT_EN
    logic [31:0] total_sold_q, total_sold_d;

    always_comb begin
        total_sold_d = total_sold_q;
        if (upd_acc && (upd_avail_pre != '0)) begin
            total_sold_d = total_sold_q + 32'd1;
        end
        if (cfg_acc && (cfg_addr == '0) && (cfg_avail == 8'hFF) && (cfg_cost == 16'hFFFF)) begin
            total_sold_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            total_sold_q <= '0;
        end else begin
            total_sold_q <= total_sold_d;
        end
    end

    assign total_sold = total_sold_q;
`endif

    assign busy          = busy_q;
    assign upd_underflow = upd_underflow_q;

endmodule
`default_nettype wire

// File: tb/tb_item_store_responder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_item_store_responder : directed vector bench for the item     |
// |   store responder (default 1024 items, read latency 2).          |
// | Revision : 1.0                                                   |
// +------------------------------------------------------------------+
module tb_item_store_responder;

    localparam int NV = 15;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        cfg_mode = 1'b0;
    logic        cfg_write_en = 1'b0;
    logic [9:0]  cfg_addr = '0;
    logic [15:0] cfg_cost = '0;
    logic [7:0]  cfg_avail = '0;
    logic        mem_read_en = 1'b0;
    logic [9:0]  mem_read_addr = '0;
    logic        mem_update_en = 1'b0;
    logic [9:0]  mem_update_addr = '0;
    logic [15:0] mem_item_cost;
    logic [7:0]  mem_item_available;
    logic        mem_data_valid;
    logic        busy;
    logic        upd_underflow;
`ifdef VEND_SALES_COUNT_EN
    logic [31:0] total_sold;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    item_store_responder dut (
        .clk                (clk),
        .rstn               (rstn),
        .cfg_mode           (cfg_mode),
        .cfg_write_en       (cfg_write_en),
        .cfg_addr           (cfg_addr),
        .cfg_cost           (cfg_cost),
        .cfg_avail          (cfg_avail),
        .mem_read_en        (mem_read_en),
        .mem_read_addr      (mem_read_addr),
        .mem_update_en      (mem_update_en),
        .mem_update_addr    (mem_update_addr),
        .mem_item_cost      (mem_item_cost),
        .mem_item_available (mem_item_available),
        .mem_data_valid     (mem_data_valid),
        .busy               (busy),
`ifdef VEND_SALES_COUNT_EN
        .total_sold         (total_sold),
`endif
        .upd_underflow      (upd_underflow)
    );

    typedef struct {
        logic        rd;
        logic [9:0]  ra;
        logic        up;
        logic [9:0]  ua;
        logic        ev;
        logic [15:0] ec;
        logic [7:0]  ea;
        logic        eu;
    } vec_t;

    vec_t tbl [NV];

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s[%0d]: got 0x%0h, expected 0x%0h", nm, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_resp(input string nm, input int idx, input logic v, input logic [15:0] c, input logic [7:0] a);
        chk({nm, "_valid"}, idx, 32'(mem_data_valid), 32'(v));
        chk({nm, "_cost"},  idx, 32'(mem_item_cost), 32'(c));
        chk({nm, "_avail"}, idx, 32'(mem_item_available), 32'(a));
    endtask

    // Holds read/update requests high through the sweep; none may be answered.
    task automatic wait_init(input int idx);
        int  busy_cycles;
        int  resp;
        bit  done;
        busy_cycles = 0;
        resp = 0;
        done = 1'b0;
        mem_read_en = 1'b1;   mem_read_addr = 10'd7;
        mem_update_en = 1'b1; mem_update_addr = 10'd7;
        for (int i = 0; i < 2200 && !done; i++) begin
            step();
            if (mem_data_valid) resp++;
            if (busy) busy_cycles++;
            else if (busy_cycles > 0) done = 1'b1;
        end
        mem_read_en = 1'b0;
        mem_update_en = 1'b0;
        chk("init_busy_cycles", idx, 32'(busy_cycles), 32'd1024);
        chk("init_no_response", idx, 32'(resp), 32'd0);
    endtask

    task automatic cfg_wr(input logic [9:0] a, input logic [15:0] c, input logic [7:0] v);
        cfg_write_en = 1'b1;
        cfg_addr = a;
        cfg_cost = c;
        cfg_avail = v;
        step();
        cfg_write_en = 1'b0;
    endtask

    initial begin
        //           rd    ra      up    ua     ev    ec       ea    eu
        tbl[0]  = '{1'b1, 10'd5, 1'b0, 10'd0, 1'b0, 16'd0,  8'd0, 1'b0};
        tbl[1]  = '{1'b1, 10'd7, 1'b0, 10'd0, 1'b1, 16'd0,  8'd0, 1'b0};
        tbl[2]  = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 16'd25, 8'd3, 1'b0};
        tbl[3]  = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 16'd0,  8'd0, 1'b0};
        tbl[4]  = '{1'b1, 10'd7, 1'b1, 10'd7, 1'b0, 16'd0,  8'd0, 1'b0};
        tbl[5]  = '{1'b1, 10'd7, 1'b0, 10'd0, 1'b1, 16'd25, 8'd2, 1'b0};
        tbl[6]  = '{1'b0, 10'd0, 1'b1, 10'd7, 1'b1, 16'd25, 8'd1, 1'b0};
        tbl[7]  = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 16'd0,  8'd0, 1'b0};
        tbl[8]  = '{1'b0, 10'd0, 1'b1, 10'd9, 1'b0, 16'd0,  8'd0, 1'b1};
        tbl[9]  = '{1'b1, 10'd9, 1'b0, 10'd0, 1'b0, 16'd0,  8'd0, 1'b0};
        tbl[10] = '{1'b1, 10'd1, 1'b0, 10'd0, 1'b1, 16'd40, 8'd0, 1'b0};
        tbl[11] = '{1'b1, 10'd2, 1'b0, 10'd0, 1'b1, 16'd11, 8'd5, 1'b0};
        tbl[12] = '{1'b1, 10'd3, 1'b0, 10'd0, 1'b1, 16'd12, 8'd6, 1'b0};
        tbl[13] = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b1, 16'd13, 8'd7, 1'b0};
        tbl[14] = '{1'b0, 10'd0, 1'b0, 10'd0, 1'b0, 16'd0,  8'd0, 1'b0};

        // Reset state
        repeat (3) step();
        chk("rst_busy", 0, 32'(busy), 32'd0);
        chk("rst_underflow", 0, 32'(upd_underflow), 32'd0);
        chk_resp("rst", 0, 1'b0, 16'd0, 8'd0);
        rstn = 1'b1;
        wait_init(0);

        // Operator configuration
        cfg_mode = 1'b1;
        step();
        cfg_wr(10'd7, 16'd25, 8'd3);
        cfg_wr(10'd9, 16'd40, 8'd0);
        cfg_wr(10'd1, 16'd11, 8'd5);
        cfg_wr(10'd2, 16'd12, 8'd6);
        cfg_wr(10'd3, 16'd13, 8'd7);
        cfg_mode = 1'b0;
        step();

        for (int i = 0; i < NV; i++) begin
            mem_read_en = tbl[i].rd;
            mem_read_addr = tbl[i].ra;
            mem_update_en = tbl[i].up;
            mem_update_addr = tbl[i].ua;
            step();
            chk_resp("vec", i, tbl[i].ev, tbl[i].ec, tbl[i].ea);
            chk("vec_underflow", i, 32'(upd_underflow), 32'(tbl[i].eu));
        end
        mem_read_en = 1'b0;
        mem_update_en = 1'b0;

        // Read pending before cfg_mode completes; reads/updates during cfg_mode are dropped
        mem_read_en = 1'b1; mem_read_addr = 10'd7;
        step();
        cfg_mode = 1'b1;
        mem_update_en = 1'b1; mem_update_addr = 10'd7;
        step();
        chk_resp("cfg_pending", 0, 1'b1, 16'd25, 8'd1);
        mem_read_en = 1'b0; mem_update_en = 1'b0;
        step();
        chk("cfg_ignored_valid", 0, 32'(mem_data_valid), 32'd0);
        chk("cfg_ignored_underflow", 0, 32'(upd_underflow), 32'd0);
        cfg_mode = 1'b0;
        step();
        mem_read_en = 1'b1; mem_read_addr = 10'd7;
        step();
        mem_read_en = 1'b0;
        step();
        chk_resp("post_cfg", 0, 1'b1, 16'd25, 8'd1);

        // Reset with a read in flight
        mem_read_en = 1'b1; mem_read_addr = 10'd1;
        step();
        mem_read_en = 1'b0;
        rstn = 1'b0;
        #1;
        chk("midrst_valid_now", 0, 32'(mem_data_valid), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("midrst_valid", i, 32'(mem_data_valid), 32'd0);
            chk("midrst_busy", i, 32'(busy), 32'd0);
        end
        rstn = 1'b1;
        wait_init(1);
        mem_read_en = 1'b1; mem_read_addr = 10'd7;
        step();
        mem_read_en = 1'b0;
        chk("resweep_early", 0, 32'(mem_data_valid), 32'd0);
        step();
        chk_resp("resweep", 0, 1'b1, 16'd0, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
